imem_boot_loader: RTL and testbench

- Boot-time program loader for the instruction memory.
- Accepts a byte stream (UART/debug bridge side) over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the instruction memory write port (wb_en/wb_address/wb_data) and holds the CPU while a load is in progress.
- Sits between the host byte link and inst_mem; it is the only writer of the memory write port.

---
 rtl/imem_boot_loader_pkg.sv | 18 +
 rtl/imem_byte_packer.sv | 36 +++
 rtl/imem_boot_loader.sv | 133 +++++++++++++
 tb/tb_imem_boot_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - state encoding and stream framing constants for the instruction memory boot loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - 8-to-32 little-endian word assembler with byte lane counter
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [LANE_W-1:0] lane_q;
  logic [23:0]       low_q;

  // The top lane is never stored: the word is presented in the same cycle its last byte arrives.
  assign word_valid = byte_valid && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word_out   = {byte_in, low_q};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_q <= '0;
      low_q  <= '0;
    end else if (byte_valid) begin
      lane_q <= lane_q + 1'b1;
      case (lane_q)
        2'd0:    low_q[7:0]   <= byte_in;
        2'd1:    low_q[15:8]  <= byte_in;
        2'd2:    low_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream program loader driving the instruction memory write port
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 21,
  parameter int CNT_W = 8 * HDR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wb_en,
  output logic [31:0] wb_address,
  output logic [31:0] wb_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_full;
  logic [IDX_W-1:0]  idx_q, wb_idx_q;
  logic              accept, last_word, word_valid;
  logic [31:0]       word_out;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign accept     = rx_valid && rx_ready;
  assign count_full = CNT_W'({rx_data, count_q[7:0]});
  assign last_word  = (CNT_W'(idx_q) + CNT_W'(1)) == count_q;

  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign cpu_hold   = (state_q != IDLE) && (state_q != DONE);
  assign wb_address = {{(32 - IDX_W){1'b0}}, wb_idx_q};

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN0;
      end
      LEN0: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = LEN1;
      end
      LEN1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (count_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else if (count_full > CNT_W'(DEPTH)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // The final word's write cycle takes no byte, so nothing slips in ahead of the state change.
        rx_ready = !(wb_en && last_word);
        if (wb_en && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      wb_en    <= 1'b0;
      wb_idx_q <= '0;
      wb_data  <= '0;
    end else begin
      state_q <= state_d;
      wb_en   <= word_valid;
      if (state_q == LEN0 && accept) count_q[7:0] <= rx_data;
      if (state_q == LEN1 && accept) begin
        count_q <= count_full;
        idx_q   <= '0;
      end else if (wb_en) begin
        idx_q <= idx_q + 1'b1;
      end
      if (word_valid) begin
        wb_idx_q <= idx_q;
        wb_data  <= word_out;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || state_q == LEN0) csum_q <= '0;
    else if (state_q == DATA && accept) csum_q <= csum_q ^ rx_data;
  end
`endif

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q != DATA),
    .byte_valid (accept && (state_q == DATA)),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word_out   (word_out)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized byte-stream bench with a byte-counting reference model of the loader
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int DEPTH = 21;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk, rst, start, rx_valid, rx_ready, wb_en, cpu_hold, done, error;
  logic [7:0]  rx_data;
  logic [31:0] wb_address, wb_data;

  imem_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .wb_en      (wb_en),
    .wb_address (wb_address),
    .wb_data    (wb_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total, bad, cyc;
  bit          chk_on;
  logic [31:0] log_addr[$], log_data[$];
  logic [7:0]  tx_q[$];

  // Reference model: the load is tracked as a count of accepted bytes since start.
  bit          m_busy;
  int          m_res;        // 0 none, 1 completed, 2 aborted
  int          m_n, m_cnt;
  logic [7:0]  m_b[$];
  logic [7:0]  m_x;
  bit          m_wen;
  int          m_addr;
  logic [31:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_ready();
    return m_busy && !(m_wen && m_addr == m_cnt - 1);
  endfunction

  task automatic finish_load(input int r);
    m_busy = 0;
    m_res  = r;
  endtask

  task automatic model_step();
    bit         acc, wen_now;
    int         idx_now;
    logic [7:0] b;
    cyc++;
    if (rst) begin
      m_busy = 0; m_res = 0; m_wen = 0; m_addr = 0; m_data = '0;
      return;
    end
    acc     = rx_valid && exp_ready();
    wen_now = m_wen;
    idx_now = m_addr;
    m_wen   = 0;
    if (m_busy) begin
      if (acc) begin
        b = rx_data;
        m_n++;
        if (m_n == 1) begin
          m_cnt = int'(b);
        end else if (m_n == 2) begin
          m_cnt = m_cnt + (int'(b) << 8);
          if (m_cnt > DEPTH) finish_load(2);
          else if (m_cnt == 0 && CS == 0) finish_load(1);
        end else if (m_n <= 2 + 4 * m_cnt) begin
          m_b.push_back(b);
          m_x = m_x ^ b;
          if ((m_n - 2) % 4 == 0) begin
            m_wen  = 1;
            m_addr = (m_n - 2) / 4 - 1;
            m_data = {m_b[m_n-3], m_b[m_n-4], m_b[m_n-5], m_b[m_n-6]};
          end
        end else begin
          finish_load((b == m_x) ? 1 : 2);
        end
      end
      if (wen_now && idx_now == m_cnt - 1 && CS == 0) finish_load(1);
    end else if (start) begin
      m_busy = 1; m_n = 0; m_res = 0; m_x = '0;
      m_b.delete();
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_on) begin
      check("rx_ready",   32'(rx_ready),   32'(exp_ready()));
      check("wb_en",      32'(wb_en),      32'(m_wen));
      check("wb_address", wb_address,      32'(m_addr));
      check("wb_data",    wb_data,         m_data);
      check("done",       32'(done),       32'(!m_busy && m_res == 1));
      check("error",      32'(error),      32'(!m_busy && m_res == 2));
      check("cpu_hold",   32'(cpu_hold),   32'(m_busy || m_res == 2));
      if (wb_en === 1'b1) begin
        log_addr.push_back(wb_address);
        log_data.push_back(wb_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    log_addr.delete();
    log_data.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit noise);
    int k;
    k = 0;
    if (noise) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        tick();
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = noise && ($urandom_range(0, 7) == 0);
    while (1) begin
      @(negedge clk);
      if (rx_ready === 1'b1) break;
      k++;
      if (k > 64) begin
        total++;
        bad++;
        $display("FAIL send_timeout: byte 0x%0h not accepted within 64 cycles", b);
        break;
      end
    end
    tick();
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send_hdr(input int cnt, input bit noise);
    send_byte(8'(cnt), noise);
    send_byte(8'(cnt >> 8), noise);
  endtask

  task automatic send_load(input int cnt, input bit noise, input bit bad_cs);
    logic [7:0] x;
    x = '0;
    pulse_start();
    send_hdr(cnt, noise);
    if (cnt > DEPTH) return;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], noise);
      x = x ^ tx_q[i];
    end
    if (CS == 1) send_byte(bad_cs ? (x ^ 8'h01) : x, noise);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, r;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick();
    chk_on = 1;
    tick();
    rst = 1'b0;

    // Idle with a byte offered but no start: nothing may be accepted.
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (10) tick();
    check("idle_ready", 32'(rx_ready), 32'd0);
    check("idle_hold",  32'(cpu_hold), 32'd0);
    check("idle_done",  32'(done | error | wb_en), 32'd0);
    check("idle_addr",  wb_address, 32'd0);
    check("idle_writes", log_addr.size(), 32'd0);
    rx_valid = 1'b0;

    // Two-word load.
    tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_load(2, 0, 0);
    idle(3);
    check("two_nwr",   log_addr.size(), 32'd2);
    check("two_a0",    log_addr[0], 32'd0);
    check("two_d0",    log_data[0], 32'h0000_0013);
    check("two_a1",    log_addr[1], 32'd1);
    check("two_d1",    log_data[1], 32'h0000_006F);
    check("two_done",  32'(done), 32'd1);
    check("two_hold",  32'(cpu_hold), 32'd0);

    // Oversize count is rejected after the header.
    tx_q.delete();
    send_load(22, 0, 0);
    idle(5);
    check("big_err",   32'(error), 32'd1);
    check("big_hold",  32'(cpu_hold), 32'd1);
    check("big_ready", 32'(rx_ready), 32'd0);
    check("big_nwr",   log_addr.size(), 32'd0);

    // Stall mid-word.
    pulse_start();
    send_hdr(1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    idle(5);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    if (CS == 1) send_byte(8'h00, 0);
    idle(3);
    check("stall_nwr",  log_addr.size(), 32'd1);
    check("stall_a",    log_addr[0], 32'd0);
    check("stall_d",    log_data[0], 32'hDDCC_BBAA);
    check("stall_done", 32'(done), 32'd1);

    // Reset mid-load, then a fresh load restarts at word 0.
    pulse_start();
    send_hdr(1, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    tick();
    check("rst_hold",  32'(cpu_hold), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_hold2", 32'(cpu_hold), 32'd0);
    tx_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    send_load(1, 0, 0);
    idle(3);
    check("rst_nwr",  log_addr.size(), 32'd1);
    check("rst_a",    log_addr[0], 32'd0);
    check("rst_d",    log_data[0], 32'h1234_5678);

    // Full-depth load.
    tx_q.delete();
    repeat (4 * DEPTH) tx_q.push_back(8'($urandom));
    send_load(DEPTH, 1, 0);
    idle(3);
    check("full_nwr",  log_addr.size(), 32'(DEPTH));
    check("full_last", log_addr[DEPTH-1], 32'(DEPTH - 1));
    check("full_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_load(1, 0, 0);
    idle(3);
    check("cs_ok_done", 32'(done), 32'd1);
    send_load(1, 0, 1);
    idle(3);
    check("cs_bad_err",  32'(error), 32'd1);
    check("cs_bad_hold", 32'(cpu_hold), 32'd1);
    check("cs_bad_nwr",  log_addr.size(), 32'd1);
`endif

    // Randomized loads, aborts and resets.
    repeat (40) begin
      r   = $urandom_range(0, 9);
      cnt = (r == 0) ? $urandom_range(DEPTH + 1, 40) : (r == 1) ? 0 : $urandom_range(1, DEPTH);
      tx_q.delete();
      repeat (4 * cnt) tx_q.push_back(8'($urandom));
      if (r == 2) begin
        pulse_start();
        send_hdr(cnt, 1);
        repeat ($urandom_range(0, 4 * cnt - 1)) send_byte(8'($urandom), 1);
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end else begin
        send_load(cnt, 1, $urandom_range(0, 3) == 0);
      end
      idle($urandom_range(1, 3));
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
